// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32 size codes,
// lane byte-enable helper and the default tohost address.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    localparam logic [31:0] DEFAULT_MMIO_ADDR = 32'hFFFF_FFF0;

    function automatic logic isLegalSize(logic [2:0] code);
        case (code)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byteEnable(logic [2:0] code, logic [1:0] lane);
        case (code)
            SZ_B, SZ_BU: return 4'b0001 << lane;
            SZ_H, SZ_HU: return lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage bus between the pipeline (master) and the data memory (slave).
interface dmem_responder_if;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic        dmemWen;
    logic        dmemRen;
    logic [2:0]  dmemSize;
    logic [31:0] dmemRdata;

    modport master (output dmemAddr, dmemWdata, dmemWen, dmemRen, dmemSize,
                    input  dmemRdata);
    modport slave  (input  dmemAddr, dmemWdata, dmemWen, dmemRen, dmemSize,
                    output dmemRdata);
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store replication/byte-enables and
// load extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] rawWord,
    input  logic [31:0] wdata,
    output logic [3:0]  byteEn,
    output logic [31:0] writeWord,
    output logic [31:0] readData,
    output logic        misalign
);
    logic [31:0] shifted;

    assign byteEn  = byteEnable(size, lane);
    assign shifted = rawWord >> {lane, 3'b000};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
        writeWord = wdata;
        readData  = '0;
        misalign  = 1'b0;
        case (size)
            SZ_B: begin
                writeWord = {4{wdata[7:0]}};
                readData  = {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_BU: begin
                writeWord = {4{wdata[7:0]}};
                readData  = {24'd0, shifted[7:0]};
            end
            SZ_H: begin
                writeWord = {2{wdata[15:0]}};
                readData  = {{16{shifted[15]}}, shifted[15:0]};
                misalign  = lane[0];
            end
            SZ_HU: begin
                writeWord = {2{wdata[15:0]}};
                readData  = {16'd0, shifted[15:0]};
                misalign  = lane[0];
            end
            SZ_W: begin
                readData  = rawWord;
                misalign  = (lane != 2'b00);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled word array, sticky error capture and
// load/store counters. Define DMEM_MMIO_EN to add the tohost MMIO register.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] MMIO_ADDR   = DEFAULT_MMIO_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus,
    output logic               errFlag,
    output logic [31:0]        errAddr,
    output logic               errIsStore,
    output logic [31:0]        loadCount,
    output logic [31:0]        storeCount,
    output logic [31:0]        tohost,
    output logic               tohostValid
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      offset;
    logic [IDX_W-1:0] wordIdx;
    logic             outOfRange;
    logic             isMmio;
    logic             bad;
    logic             storeFire;
    logic             loadFire;
    logic [3:0]       byteEn;
    logic [31:0]      writeWord;
    logic [31:0]      alignedRead;
    logic             misalign;

    // BASE_ADDR is DEPTH_WORDS*4 aligned, so offset[1:0] is the byte lane.
    assign offset     = bus.dmemAddr - BASE_ADDR;
    assign wordIdx    = offset[IDX_W+1:2];
    assign outOfRange = (offset >> (IDX_W + 2)) != 32'd0;

    dmem_lane_align uAlign (
        .size      (bus.dmemSize),
        .lane      (offset[1:0]),
        .rawWord   (mem[wordIdx]),
        .wdata     (bus.dmemWdata),
        .byteEn    (byteEn),
        .writeWord (writeWord),
        .readData  (alignedRead),
        .misalign  (misalign)
    );

`ifdef DMEM_MMIO_EN
    assign isMmio = (bus.dmemAddr == MMIO_ADDR);
`else
    assign isMmio = 1'b0;
`endif

    // The tohost register only accepts full words; anything else there is an error.
    assign bad = !isLegalSize(bus.dmemSize) || misalign ||
                 (isMmio ? (bus.dmemSize != SZ_W) : outOfRange);

    assign storeFire = bus.dmemWen && !bad && !isMmio;
    assign loadFire  = bus.dmemRen && !bus.dmemWen && !bad;

    // NOTE: the array has no reset; clearing it would turn it into flops, and a store
    // coinciding with reset still lands because this block ignores rst.
    always_ff @(posedge clk) begin
        if (storeFire) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= writeWord[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            errFlag    <= 1'b0;
            errAddr    <= '0;
            errIsStore <= 1'b0;
            loadCount  <= '0;
            storeCount <= '0;
        end else begin
            if (storeFire) storeCount <= storeCount + 32'd1;
            if (loadFire)  loadCount  <= loadCount + 32'd1;
            if ((bus.dmemWen || bus.dmemRen) && bad && !errFlag) begin
                errFlag    <= 1'b1;
                errAddr    <= bus.dmemAddr;
                errIsStore <= bus.dmemWen;
            end
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            tohost      <= '0;
            tohostValid <= 1'b0;
        end else begin
            tohostValid <= isMmio && bus.dmemWen && !bad;
            if (isMmio && bus.dmemWen && !bad) tohost <= bus.dmemWdata;
        end
    end
`else
    assign tohost      = '0;
    assign tohostValid = 1'b0;
`endif

    always_comb begin
        bus.dmemRdata = '0;
        if (rst && !bad) bus.dmemRdata = isMmio ? tohost : alignedRead;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (define DMEM_MMIO_EN to cover tohost).
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int          DEPTH = 256;
    localparam logic [31:0] MMIO  = DEFAULT_MMIO_ADDR;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        errFlag;
    logic [31:0] errAddr;
    logic        errIsStore;
    logic [31:0] loadCount;
    logic [31:0] storeCount;
    logic [31:0] tohost;
    logic        tohostValid;

    int errors = 0;
    int checks = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .INIT_FILE   (""),
        .MMIO_ADDR   (MMIO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .errFlag     (errFlag),
        .errAddr     (errAddr),
        .errIsStore  (errIsStore),
        .loadCount   (loadCount),
        .storeCount  (storeCount),
        .tohost      (tohost),
        .tohostValid (tohostValid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge and settle 1ns before being checked.
    task automatic drive(input logic wen, input logic ren, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.dmemWen   = wen;
        bus.dmemRen   = ren;
        bus.dmemSize  = size;
        bus.dmemAddr  = addr;
        bus.dmemWdata = wdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        drive(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state; rdata forced to zero while rst is low
        drive(1'b0, 1'b1, SZ_W, 32'h10, 32'h0);
        tick();
        tick();
        check("rst_rdata", bus.dmemRdata, 32'h0);
        check("rst_errFlag", errFlag, 32'd0);
        check("rst_errAddr", errAddr, 32'h0);
        check("rst_loadCount", loadCount, 32'd0);
        check("rst_storeCount", storeCount, 32'd0);
        check("rst_tohost", tohost, 32'h0);
        check("rst_tohostValid", tohostValid, 32'd0);
        rst = 1'b1;

        // Word store then loads of every width
        drive(1'b1, 1'b0, SZ_W, 32'h10, 32'hDEAD_BEEF); tick();
        drive(1'b0, 1'b1, SZ_W, 32'h10, 32'h0);
        check("lw_10", bus.dmemRdata, 32'hDEAD_BEEF); tick();
        drive(1'b0, 1'b1, SZ_B, 32'h13, 32'h0);
        check("lb_13", bus.dmemRdata, 32'hFFFF_FFDE); tick();
        drive(1'b0, 1'b1, SZ_H, 32'h12, 32'h0);
        check("lh_12", bus.dmemRdata, 32'hFFFF_DEAD); tick();
        check("loadCount_3", loadCount, 32'd3);
        check("storeCount_1", storeCount, 32'd1);
        drive(1'b0, 1'b1, SZ_BU, 32'h13, 32'h0);
        check("lbu_13", bus.dmemRdata, 32'h0000_00DE); tick();

        // Byte and half stores merge into the existing word
        drive(1'b1, 1'b0, SZ_B, 32'h11, 32'hAAAA_AA55); tick();
        drive(1'b0, 1'b1, SZ_W, 32'h10, 32'h0);
        check("sb_merge", bus.dmemRdata, 32'hDEAD_55EF); tick();
        drive(1'b1, 1'b0, SZ_H, 32'h12, 32'hFFFF_1234);
        check("store_cycle_prewrite", bus.dmemRdata, 32'hFFFF_DEAD); tick();
        drive(1'b0, 1'b1, SZ_W, 32'h10, 32'h0);
        check("sh_merge", bus.dmemRdata, 32'h1234_55EF); tick();
        drive(1'b0, 1'b1, SZ_HU, 32'h12, 32'h0);
        check("lhu_12", bus.dmemRdata, 32'h0000_1234); tick();

        // Misaligned store is suppressed and captured
        drive(1'b1, 1'b0, SZ_W, 32'h20, 32'hCAFE_F00D); tick();
        drive(1'b1, 1'b0, SZ_W, 32'h22, 32'h1111_1111); tick();
        check("mis_errFlag", errFlag, 32'd1);
        check("mis_errAddr", errAddr, 32'h22);
        check("mis_errIsStore", errIsStore, 32'd1);
        check("mis_storeCount", storeCount, 32'd4);
        drive(1'b0, 1'b1, SZ_W, 32'h20, 32'h0);
        check("mis_word_intact", bus.dmemRdata, 32'hCAFE_F00D); tick();
        drive(1'b0, 1'b1, SZ_H, 32'h31, 32'h0);
        check("lh_odd_rdata", bus.dmemRdata, 32'h0); tick();
        check("sticky_errAddr", errAddr, 32'h22);
        check("sticky_errIsStore", errIsStore, 32'd1);
        check("bad_load_uncounted", loadCount, 32'd8);

        // Store in cycle N, reset in N+1, load in N+2; store during reset still lands
        drive(1'b1, 1'b0, SZ_W, 32'h40, 32'h0BAD_F00D); tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, SZ_W, 32'h0, 32'h0); tick();
        check("rst2_storeCount", storeCount, 32'd0);
        check("rst2_loadCount", loadCount, 32'd0);
        check("rst2_errFlag", errFlag, 32'd0);
        check("rst2_errAddr", errAddr, 32'h0);
        drive(1'b1, 1'b0, SZ_W, 32'h44, 32'h600D_CAFE); tick();
        check("rst_store_uncounted", storeCount, 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b1, SZ_W, 32'h40, 32'h0);
        check("post_rst_lw", bus.dmemRdata, 32'h0BAD_F00D); tick();
        drive(1'b0, 1'b1, SZ_W, 32'h44, 32'h0);
        check("rst_cycle_store", bus.dmemRdata, 32'h600D_CAFE); tick();

        // Out-of-range load
        drive(1'b0, 1'b1, SZ_W, DEPTH * 4, 32'h0);
        check("oor_rdata", bus.dmemRdata, 32'h0); tick();
        check("oor_errFlag", errFlag, 32'd1);
        check("oor_errAddr", errAddr, DEPTH * 4);
        check("oor_errIsStore", errIsStore, 32'd0);
        check("oor_loadCount", loadCount, 32'd2);

        // tohost register
        doReset();
        drive(1'b1, 1'b0, SZ_W, MMIO, 32'h1); tick();
`ifdef DMEM_MMIO_EN
        check("mmio_tohost", tohost, 32'h1);
        check("mmio_valid_hi", tohostValid, 32'd1);
        check("mmio_errFlag", errFlag, 32'd0);
        check("mmio_storeCount", storeCount, 32'd0);
        drive(1'b0, 1'b1, SZ_W, MMIO, 32'h0);
        check("mmio_lw", bus.dmemRdata, 32'h1); tick();
        check("mmio_valid_lo", tohostValid, 32'd0);
`else
        check("nommio_errFlag", errFlag, 32'd1);
        check("nommio_errAddr", errAddr, MMIO);
        check("nommio_tohost", tohost, 32'h0);
        check("nommio_valid", tohostValid, 32'd0);
`endif

        // Illegal size codes and simultaneous load/store
        doReset();
        drive(1'b0, 1'b1, 3'b011, 32'h10, 32'h0);
        check("ill_rdata", bus.dmemRdata, 32'h0); tick();
        check("ill_errFlag", errFlag, 32'd1);
        check("ill_errAddr", errAddr, 32'h10);
        check("ill_errIsStore", errIsStore, 32'd0);
        drive(1'b1, 1'b0, 3'b110, 32'h10, 32'h0); tick();
        check("ill_store_uncounted", storeCount, 32'd0);
        drive(1'b0, 1'b1, SZ_W, 32'h10, 32'h0);
        check("ill_store_suppressed", bus.dmemRdata, 32'h1234_55EF); tick();
        drive(1'b1, 1'b1, SZ_W, 32'h50, 32'h7777_7777); tick();
        check("both_storeCount", storeCount, 32'd1);
        check("both_loadCount", loadCount, 32'd1);
        drive(1'b0, 1'b1, SZ_W, 32'h50, 32'h0);
        check("both_written", bus.dmemRdata, 32'h7777_7777); tick();
        check("final_loadCount", loadCount, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
